// File: rtl/button_event_source.sv
`default_nettype none
// ============================================================================
// Module   : button_event_source
// Purpose  : Synchronizes and debounces btnC, then emits press/release/long strobes.
//            Build option: define AUTO_REPEAT_EN to re-fire press_pulse while held long.
// Revision : 1.0
// ============================================================================
module button_event_source #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btnC,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic held_long
);

  localparam int MAX_DL  = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int MAX_ALL = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             held_q, held_d;
  logic             rise, fall;
  logic [CNT_W-1:0] hold_inc;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LIM = CNT_W'(REPEAT_CYCLES);
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] rep_inc;
`endif

  always_comb begin
    s1_d      = btnC;
    s2_d      = s1_q;
    deb_d     = deb_q;
    level_d   = level_q;
    state_d   = state_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    held_d    = held_q;
    rise      = 1'b0;
    fall      = 1'b0;
    hold_inc  = (hold_q >= LONG_LIM) ? hold_q : hold_q + ONE;
`ifdef AUTO_REPEAT_EN
    rep_d     = rep_q;
    rep_inc   = (rep_q >= REP_LIM) ? rep_q : rep_q + ONE;
`endif

    // The count must sit at the limit for one extra cycle before the level flips.
    if (s2_q != level_q) begin
      if (deb_q >= DEB_LIM) begin
        level_d = s2_q;
        deb_d   = '0;
        rise    = s2_q;
        fall    = ~s2_q;
      end else begin
        deb_d = deb_q + ONE;
      end
    end else begin
      deb_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESS;
          press_d = 1'b1;
          hold_d  = '0;
        end
      end
      PRESS: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          held_d    = 1'b0;
          hold_d    = '0;
        end else begin
          hold_d = hold_inc;
          if (hold_inc == LONG_LIM) begin
            state_d = LONG;
            long_d  = 1'b1;
            held_d  = 1'b1;
`ifdef AUTO_REPEAT_EN
            rep_d   = '0;
`endif
          end
        end
      end
      LONG: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          held_d    = 1'b0;
          hold_d    = '0;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (rep_inc == REP_LIM) begin
            press_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_inc;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        held_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      deb_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
`ifdef AUTO_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign held_long     = held_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_source.sv
`default_nettype none
// Bench for button_event_source: timestamp-based event model, per-cycle compare,
// directed scenarios with literal timings, then randomized bouncing input.
module tb_button_event_source;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 6;

  logic clk = 1'b0;
  logic rst;
  logic btnC;
  logic btn_level, press_pulse, release_pulse, long_pulse, held_long;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  button_event_source #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btnC         (btnC),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .held_long    (held_long)
  );

  always #5 clk = ~clk;

`ifdef AUTO_REPEAT_EN
  localparam int REPEATS_IN_HOLD = 6;
`else
  localparam int REPEATS_IN_HOLD = 0;
`endif

  // Model state: pipeline of raw samples, disagreement run length, event timestamps
  bit m_p1, m_p2, m_level, m_in_press, m_held;
  bit e_press, e_rel, e_long;
  int m_run, m_press_t, m_long_t;
  // Event bookkeeping from the DUT and from the model
  int d_n_press = 0, d_n_rel = 0, d_n_long = 0;
  int d_last_press = -1, d_last_rel = -1, d_last_long = -1;
  int m_n_press = 0, m_last_press = -1, m_last_long = -1;

  initial begin
    bit s2, rise, fall;
    logic [4:0] act, exp;
    forever begin
      @(posedge clk);
      cyc++;
      e_press = 0; e_rel = 0; e_long = 0;
      if (rst) begin
        m_p1 = 0; m_p2 = 0; m_level = 0; m_run = 0;
        m_in_press = 0; m_held = 0;
      end else begin
        s2   = m_p2;
        m_p2 = m_p1;
        m_p1 = btnC;
        rise = 0; fall = 0;
        // Level flips once D+1 consecutive synced samples disagree with it
        if (s2 != m_level) begin
          m_run++;
          if (m_run == D + 1) begin
            m_level = s2; m_run = 0; rise = s2; fall = !s2;
          end
        end else begin
          m_run = 0;
        end
        if (rise) begin
          e_press = 1; m_in_press = 1; m_press_t = cyc;
        end else if (fall) begin
          e_rel = 1; m_in_press = 0; m_held = 0;
        end else if (m_in_press && (cyc - m_press_t == L)) begin
          e_long = 1; m_in_press = 0; m_held = 1; m_long_t = cyc;
        end
`ifdef AUTO_REPEAT_EN
        else if (m_held && ((cyc - m_long_t) % R == 0)) begin
          e_press = 1;
        end
`endif
      end
      if (e_press) begin m_n_press++; m_last_press = cyc; end
      if (e_long) m_last_long = cyc;
      #1;
      act = {btn_level, press_pulse, release_pulse, long_pulse, held_long};
      exp = {m_level, e_press, e_rel, e_long, m_held};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL outputs cyc=%0d {lvl,press,rel,long,held} actual=%b expected=%b", cyc, act, exp);
      end
      if (press_pulse === 1'b1) begin d_n_press++; d_last_press = cyc; end
      if (release_pulse === 1'b1) begin d_n_rel++; d_last_rel = cyc; end
      if (long_pulse === 1'b1) begin d_n_long++; d_last_long = cyc; end
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int e, f, np0, nr0, nl0;
    rst  = 1'b1;
    btnC = 1'b1;
    tick(3);
    chk("reset_level", int'(btn_level), 0);
    chk("reset_held", int'(held_long), 0);
    chk("reset_no_press", d_n_press, 0);
    rst = 1'b0;
    e = cyc + 1;
    tick(12);
    chk("first_press_time", d_last_press, e + 6);
    chk("model_first_press_time", m_last_press, e + 6);
    chk("first_press_count", d_n_press, 1);
    chk("level_after_press", int'(btn_level), 1);

    btnC = 1'b0;
    tick(12);
    chk("release_level", int'(btn_level), 0);

    // Glitch shorter than the debounce window
    np0 = d_n_press; nr0 = d_n_rel;
    btnC = 1'b1;
    tick(3);
    btnC = 1'b0;
    tick(12);
    chk("glitch_no_press", d_n_press, np0);
    chk("glitch_no_release", d_n_rel, nr0);
    chk("glitch_level", int'(btn_level), 0);

    // Long hold: btnC held 60 cycles
    np0 = d_n_press;
    btnC = 1'b1;
    e = cyc + 1;
    tick(60);
    btnC = 1'b0;
    f = cyc + 1;
    tick(12);
    chk("long_time", d_last_long, e + 26);
    chk("model_long_time", m_last_long, e + 26);
    chk("release_time", d_last_rel, f + 6);
    chk("hold_press_count", d_n_press - np0, 1 + REPEATS_IN_HOLD);
    chk("last_press_time", d_last_press, (REPEATS_IN_HOLD != 0) ? e + 62 : e + 6);
    chk("held_after_release", int'(held_long), 0);

    // Reset in the middle of a press with the button still held
    btnC = 1'b1;
    tick(10);
    nr0 = d_n_rel; nl0 = d_n_long;
    rst = 1'b1;
    tick(1);
    chk("midreset_level", int'(btn_level), 0);
    rst = 1'b0;
    e = cyc + 1;
    tick(10);
    chk("midreset_no_release", d_n_rel, nr0);
    chk("midreset_no_long", d_n_long, nl0);
    chk("midreset_repress_time", d_last_press, e + 6);
    btnC = 1'b0;
    tick(12);

    // Randomized bouncing input with occasional resets
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        tick($urandom_range(1, 3));
        rst = 1'b0;
      end
      btnC = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 40));
    end
    btnC = 1'b0;
    tick(20);
    chk("model_press_count", m_n_press, d_n_press);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
